// File: rtl/veda_sp_ram_if.sv
// -----------------------------------------------------------------------------
// veda_sp_ram_if
// Request/response bus of the veda_sp_ram scratch store.
//   master : requester side. It drives req_valid, mode, address, data_in and
//            byte_en. It samples req_ready, data_out, rsp_valid, rsp_err and
//            init_done.
//   slave  : RAM side, with the opposite directions.
// The interface carries no clock or reset. Those stay as plain module ports.
// -----------------------------------------------------------------------------
interface veda_sp_ram_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  mode;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W-1:0]     data_in;
    logic [DATA_W/8-1:0]   byte_en;
    logic [DATA_W-1:0]     data_out;
    logic                  rsp_valid;
    logic                  rsp_err;
    logic                  init_done;

    modport master (
        output req_valid, mode, address, data_in, byte_en,
        input  req_ready, data_out, rsp_valid, rsp_err, init_done
    );

    modport slave (
        input  req_valid, mode, address, data_in, byte_en,
        output req_ready, data_out, rsp_valid, rsp_err, init_done
    );
endinterface

// File: rtl/veda_sp_ram.sv
// -----------------------------------------------------------------------------
// veda_sp_ram
// Parametrised single-port synchronous RAM with the following features:
//   - byte-enable writes
//   - write-through responses
//   - a valid/ready request handshake
//   - a read latency of 1 or 2 cycles
// After reset a clear sequencer zeroes one word per cycle. Requests are
// accepted only once every word has been cleared.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : veda_sp_ram_if.slave. It carries the request fields, the
//            response fields and init_done.
// -----------------------------------------------------------------------------
module veda_sp_ram #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int READ_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    veda_sp_ram_if.slave    bus
);
    localparam int                NB       = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                req_ready_s;
    logic                init_done_s;
    logic                clear_en_s;
    logic                accept_s;
    logic                addr_ok_s;
    logic [DATA_W-1:0]   rd_word_s;
    logic [DATA_W-1:0]   merged_s;
    logic [DATA_W-1:0]   rsp_data_s;
    logic                rsp_err_s;
    logic                wr_en_s;
    logic [ADDR_W-1:0]   wr_addr_s;
    logic [DATA_W-1:0]   wr_data_s;

    logic                s1_valid_q;
    logic [DATA_W-1:0]   s1_data_q;
    logic                s1_err_q;

    // FSM state register and clear pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= {ADDR_W{1'b0}};
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // FSM next state. The clear pointer stops at the last word.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_ptr_q == LAST_PTR) begin
                    state_d = ST_READY;
                end else begin
                    clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_ptr_d = {ADDR_W{1'b0}};
            end
        endcase
    end

    // FSM outputs, decoded from the state register alone.
    always_comb begin
        req_ready_s = 1'b0;
        init_done_s = 1'b0;
        clear_en_s  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clear_en_s = 1'b1;
            end
            ST_READY: begin
                req_ready_s = 1'b1;
                init_done_s = 1'b1;
            end
            default: begin
                clear_en_s = 1'b0;
            end
        endcase
    end

    assign accept_s  = bus.req_valid && req_ready_s;
    assign addr_ok_s = ({1'b0, bus.address} < DEPTH_L);

    // Current word at the request address, and the byte-merged write word.
    // With byte_en all zero the merge reproduces the stored word.
    always_comb begin
        if (addr_ok_s) begin
            rd_word_s = mem_q[bus.address];
        end else begin
            rd_word_s = {DATA_W{1'b0}};
        end
        merged_s = rd_word_s;
        for (int i = 0; i < NB; i++) begin
            if (bus.byte_en[i]) begin
                merged_s[8*i +: 8] = bus.data_in[8*i +: 8];
            end else begin
                merged_s[8*i +: 8] = rd_word_s[8*i +: 8];
            end
        end
    end

    // Response payload. Out-of-range requests return zero data with the error flag set.
    always_comb begin
        if (!addr_ok_s) begin
            rsp_data_s = {DATA_W{1'b0}};
            rsp_err_s  = 1'b1;
        end else if (bus.mode) begin
            rsp_data_s = rd_word_s;
            rsp_err_s  = 1'b0;
        end else begin
            rsp_data_s = merged_s;
            rsp_err_s  = 1'b0;
        end
    end

    // Memory write port, shared between the clear sequencer and accepted writes.
    always_comb begin
        if (clear_en_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = clr_ptr_q;
            wr_data_s = {DATA_W{1'b0}};
        end else if (accept_s && !bus.mode && addr_ok_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = bus.address;
            wr_data_s = merged_s;
        end else begin
            wr_en_s   = 1'b0;
            wr_addr_s = bus.address;
            wr_data_s = merged_s;
        end
    end

    // Storage array. No reset here; the clear sequencer zeroes the contents.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en_s) begin
            mem_q[wr_addr_s] <= wr_data_s;
        end
    end

    // First response stage. Data and err hold between responses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= {DATA_W{1'b0}};
            s1_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= accept_s;
            if (accept_s) begin
                s1_data_q <= rsp_data_s;
                s1_err_q  <= rsp_err_s;
            end
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic                s2_valid_q;
            logic [DATA_W-1:0]   s2_data_q;
            logic                s2_err_q;

            // Second response stage. It loads only when stage 1 holds a response.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s2_valid_q <= 1'b0;
                    s2_data_q  <= {DATA_W{1'b0}};
                    s2_err_q   <= 1'b0;
                end else begin
                    s2_valid_q <= s1_valid_q;
                    if (s1_valid_q) begin
                        s2_data_q <= s1_data_q;
                        s2_err_q  <= s1_err_q;
                    end
                end
            end

            assign bus.rsp_valid = s2_valid_q;
            assign bus.data_out  = s2_data_q;
            assign bus.rsp_err   = s2_err_q;
        end else begin : g_lat1
            assign bus.rsp_valid = s1_valid_q;
            assign bus.data_out  = s1_data_q;
            assign bus.rsp_err   = s1_err_q;
        end
    endgenerate

    assign bus.req_ready = req_ready_s;
    assign bus.init_done = init_done_s;

endmodule

// File: tb/tb_veda_sp_ram.sv
// -----------------------------------------------------------------------------
// tb_veda_sp_ram
// Three instances of veda_sp_ram share one clock, one reset and one request
// stream:
//   u_a : DEPTH=32, READ_LAT=1
//   u_b : DEPTH=20, READ_LAT=1
//   u_c : DEPTH=32, READ_LAT=2
// Responses are captured with a cycle stamp. They are then compared against
// hand-computed expected words, error flags and latencies.
// -----------------------------------------------------------------------------
module tb_veda_sp_ram;
    localparam int N_REQ = 21;

    typedef struct packed {
        logic        mode;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp32;
        logic [31:0] exp20;
        logic        err20;
    } vec_t;

    localparam vec_t VEC [N_REQ] = '{
        '{1'b1, 5'd0,  32'h0000_0000, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b0},
        '{1'b1, 5'd15, 32'h0000_0000, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b0},
        '{1'b1, 5'd31, 32'h0000_0000, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b1},
        '{1'b0, 5'd0,  32'h0000_00A0, 4'hF, 32'h0000_00A0, 32'h0000_00A0, 1'b0},
        '{1'b0, 5'd1,  32'h0000_00A1, 4'hF, 32'h0000_00A1, 32'h0000_00A1, 1'b0},
        '{1'b0, 5'd2,  32'h0000_00A2, 4'hF, 32'h0000_00A2, 32'h0000_00A2, 1'b0},
        '{1'b0, 5'd3,  32'h0000_00A3, 4'hF, 32'h0000_00A3, 32'h0000_00A3, 1'b0},
        '{1'b1, 5'd0,  32'hFFFF_FFFF, 4'h0, 32'h0000_00A0, 32'h0000_00A0, 1'b0},
        '{1'b1, 5'd1,  32'hFFFF_FFFF, 4'h0, 32'h0000_00A1, 32'h0000_00A1, 1'b0},
        '{1'b1, 5'd2,  32'hFFFF_FFFF, 4'h0, 32'h0000_00A2, 32'h0000_00A2, 1'b0},
        '{1'b1, 5'd3,  32'hFFFF_FFFF, 4'h0, 32'h0000_00A3, 32'h0000_00A3, 1'b0},
        '{1'b0, 5'd3,  32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0},
        '{1'b1, 5'd3,  32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0},
        '{1'b0, 5'd3,  32'h1122_3344, 4'h5, 32'hDE22_BE44, 32'hDE22_BE44, 1'b0},
        '{1'b1, 5'd3,  32'h0000_0000, 4'hF, 32'hDE22_BE44, 32'hDE22_BE44, 1'b0},
        '{1'b0, 5'd19, 32'h1234_5678, 4'hF, 32'h1234_5678, 32'h1234_5678, 1'b0},
        '{1'b0, 5'd25, 32'hFFFF_FFFF, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1},
        '{1'b1, 5'd25, 32'h0000_0000, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1},
        '{1'b0, 5'd5,  32'h5566_7788, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b0},
        '{1'b1, 5'd5,  32'h0000_0000, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b0},
        '{1'b1, 5'd19, 32'h0000_0000, 4'hF, 32'h1234_5678, 32'h1234_5678, 1'b0}
    };

    typedef struct {
        int          dut;
        int          cyc;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        mode;
    logic [4:0]  address;
    logic [31:0] data_in;
    logic [3:0]  byte_en;

    logic [2:0]  rv, re, rdy, idn;
    logic [31:0] rd [3];

    int          cyc;
    int          n_checks;
    int          n_errors;
    logic        mon_en;
    rsp_t        mon_q[$];

    veda_sp_ram_if #(.DATA_W(32), .ADDR_W(5)) if_a ();
    veda_sp_ram_if #(.DATA_W(32), .ADDR_W(5)) if_b ();
    veda_sp_ram_if #(.DATA_W(32), .ADDR_W(5)) if_c ();

    veda_sp_ram #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .READ_LAT(1))
        u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    veda_sp_ram #(.DATA_W(32), .ADDR_W(5), .DEPTH(20), .READ_LAT(1))
        u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    veda_sp_ram #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .READ_LAT(2))
        u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    assign if_a.req_valid = req_valid;
    assign if_a.mode      = mode;
    assign if_a.address   = address;
    assign if_a.data_in   = data_in;
    assign if_a.byte_en   = byte_en;

    assign if_b.req_valid = req_valid;
    assign if_b.mode      = mode;
    assign if_b.address   = address;
    assign if_b.data_in   = data_in;
    assign if_b.byte_en   = byte_en;

    assign if_c.req_valid = req_valid;
    assign if_c.mode      = mode;
    assign if_c.address   = address;
    assign if_c.data_in   = data_in;
    assign if_c.byte_en   = byte_en;

    assign rv  = {if_c.rsp_valid, if_b.rsp_valid, if_a.rsp_valid};
    assign re  = {if_c.rsp_err,   if_b.rsp_err,   if_a.rsp_err};
    assign rdy = {if_c.req_ready, if_b.req_ready, if_a.req_ready};
    assign idn = {if_c.init_done, if_b.init_done, if_a.init_done};
    assign rd[0] = if_a.data_out;
    assign rd[1] = if_b.data_out;
    assign rd[2] = if_c.data_out;

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to stamp captured responses
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Response capture at the falling edge, away from the active edge
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 3; d++) begin
                if (rv[d]) begin
                    mon_q.push_back('{dut: d, cyc: cyc, data: rd[d], err: re[d]});
                end
            end
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Count clock edges from reset release until init_done. Also count any
    // cycle where req_ready is high before init_done.
    task automatic wait_init(input string tag, input int exp_a, input int exp_b);
        int cnt;
        int cnt_b;
        int early;
        cnt   = 0;
        cnt_b = -1;
        early = 0;
        while (!(idn[0] && idn[2]) && cnt < 100) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (idn[1] && cnt_b < 0) cnt_b = cnt;
            for (int d = 0; d < 3; d++) begin
                if (rdy[d] && !idn[d]) early++;
            end
        end
        chk_eq({tag, "_init_cycles_d32"}, 32'(cnt), 32'(exp_a));
        chk_eq({tag, "_init_cycles_d20"}, 32'(cnt_b), 32'(exp_b));
        chk_eq({tag, "_init_lat2"}, {31'd0, idn[2]}, 32'd1);
        chk_eq({tag, "_ready_early"}, 32'(early), 32'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk_eq($sformatf("%s_d%0d_data", tag, d), rd[d], 32'h0);
            chk_eq($sformatf("%s_d%0d_valid", tag, d), {31'd0, rv[d]}, 32'd0);
            chk_eq($sformatf("%s_d%0d_err", tag, d), {31'd0, re[d]}, 32'd0);
            chk_eq($sformatf("%s_d%0d_init", tag, d), {31'd0, idn[d]}, 32'd0);
            chk_eq($sformatf("%s_d%0d_ready", tag, d), {31'd0, rdy[d]}, 32'd0);
        end
    endtask

    initial begin
        int base;
        int k;
        int lat;
        cyc       = 0;
        n_checks  = 0;
        n_errors  = 0;
        mon_en    = 1'b0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        mode      = 1'b0;
        address   = 5'd0;
        data_in   = 32'h0;
        byte_en   = 4'h0;

        // Power-on reset
        repeat (3) @(negedge clk);
        chk_reset_state("por");
        rst_n = 1'b1;
        wait_init("por", 32, 20);

        // Reset mid-CLEAR, when clr_ptr has reached 10
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_state("midclr");
        rst_n = 1'b1;
        wait_init("midclr", 32, 20);

        // Back-to-back directed request stream
        mon_q.delete();
        mon_en = 1'b1;
        base   = cyc;
        for (int i = 0; i < N_REQ; i++) begin
            req_valid = 1'b1;
            mode      = VEC[i].mode;
            address   = VEC[i].addr;
            data_in   = VEC[i].data;
            byte_en   = VEC[i].be;
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        mon_en = 1'b0;

        for (int d = 0; d < 3; d++) begin
            k   = 0;
            lat = (d == 2) ? 2 : 1;
            foreach (mon_q[j]) begin
                if (mon_q[j].dut == d) begin
                    if (k < N_REQ) begin
                        chk_eq($sformatf("d%0d_data_%0d", d, k), mon_q[j].data,
                               (d == 1) ? VEC[k].exp20 : VEC[k].exp32);
                        chk_eq($sformatf("d%0d_err_%0d", d, k), {31'd0, mon_q[j].err},
                               {31'd0, (d == 1) ? VEC[k].err20 : 1'b0});
                        chk_eq($sformatf("d%0d_lat_%0d", d, k), 32'(mon_q[j].cyc),
                               32'(base + k + lat));
                    end
                    k++;
                end
            end
            chk_eq($sformatf("d%0d_rsp_count", d), 32'(k), 32'(N_REQ));
        end

        // Outputs hold the last response while idle
        for (int d = 0; d < 3; d++) begin
            chk_eq($sformatf("d%0d_hold_valid", d), {31'd0, rv[d]}, 32'd0);
            chk_eq($sformatf("d%0d_hold_data", d), rd[d], 32'h1234_5678);
            chk_eq($sformatf("d%0d_hold_err", d), {31'd0, re[d]}, 32'd0);
        end

        // Reset while a read is in flight. The second stage of u_c is discarded.
        req_valid = 1'b1;
        mode      = 1'b1;
        address   = 5'd3;
        byte_en   = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        chk_reset_state("inflight");
        mon_q.delete();
        mon_en = 1'b1;
        rst_n  = 1'b1;
        wait_init("inflight", 32, 20);
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        chk_eq("inflight_stale_valid", 32'(mon_q.size()), 32'd0);
        for (int d = 0; d < 3; d++) begin
            chk_eq($sformatf("inflight_d%0d_data_zero", d), rd[d], 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
